debug_mem_arbiter: RTL and testbench

//  Shares one single-ported memory (imem or dmem, one instance each) between the CPU pipeline and the

---
 rtl/raisin64_debug_pkg.sv | 7 +
 rtl/arb_watchdog.sv | 19 +
 rtl/debug_mem_arbiter.sv | 99 +++++++++
 tb/tb_debug_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_debug_pkg.sv
// raisin64_debug_pkg: arbiter state encodings and constants shared by the debug memory path
package raisin64_debug_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DBG} arb_state_t;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int MAX_DATA_W = 256;
    localparam logic [MAX_DATA_W-1:0] ABORT_DATA = '1;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts cycles of a granted access and flags expiry after TIMEOUT cycles
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic cpu_clk,
    input  logic sys_rstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // fires on the edge that ends the TIMEOUT-th enabled cycle
    always_comb expire = enable && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge cpu_clk or negedge sys_rstn)
        if (!sys_rstn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/debug_mem_arbiter.sv
// debug_mem_arbiter: shares one memory port between the CPU and a latched debug request slot
module debug_mem_arbiter
    import raisin64_debug_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              cpu_clk,
    input  logic              sys_rstn,
    input  logic              cpu_halt,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_ce,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rdata_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              dbg_overrun,
    output logic              timeout_err
);
    localparam logic [DATA_W-1:0] ABORT = DATA_W'(ABORT_DATA);
    arb_state_t state;
    logic pending, pend_we, expire, grant_dbg, grant_cpu, done;
    // a debug pulse arriving this edge also blocks the CPU so debug wins the tie
    always_comb begin
        grant_dbg = state == ARB_IDLE && pending;
        grant_cpu = state == ARB_IDLE && !pending && !dbg_ce && cpu_ce && !cpu_halt && !cpu_ready;
        done      = state != ARB_IDLE && (mem_ready || expire);
    end
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .cpu_clk (cpu_clk),
        .sys_rstn(sys_rstn),
        .clear   (grant_dbg || grant_cpu),
        .enable  (state != ARB_IDLE),
        .expire  (expire)
    );
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state           <= ARB_IDLE;
            pending         <= 1'b0;
            pend_we         <= 1'b0;
            mem_ce          <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            cpu_rdata       <= '0;
            cpu_ready       <= 1'b0;
            dbg_rdata       <= '0;
            dbg_rdata_ready <= 1'b0;
            dbg_overrun     <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            cpu_ready       <= 1'b0;
            dbg_rdata_ready <= 1'b0;
            if (dbg_ce && pending) dbg_overrun <= 1'b1;
            if (dbg_ce && !pending) begin
                pending <= 1'b1;
                pend_we <= dbg_we;
            end else if (grant_dbg) pending <= 1'b0;
            if (grant_dbg) begin
                state     <= ARB_DBG;
                mem_ce    <= 1'b1;
                mem_we    <= pend_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end else if (grant_cpu) begin
                state     <= ARB_CPU;
                mem_ce    <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (done) begin
                state  <= ARB_IDLE;
                mem_ce <= 1'b0;
                if (!mem_ready) timeout_err <= 1'b1;
                // a normal completion wins over an expiry on the same edge
                if (state == ARB_CPU) begin
                    cpu_ready <= 1'b1;
                    if (!mem_ready || !mem_we) cpu_rdata <= mem_ready ? mem_rdata : ABORT;
                end else if (!mem_we) begin
                    dbg_rdata_ready <= 1'b1;
                    dbg_rdata       <= mem_ready ? mem_rdata : ABORT;
                end
            end
        end
    end
endmodule

// File: tb/tb_debug_mem_arbiter.sv
// tb_debug_mem_arbiter: directed checks of arbitration, completion routing, watchdog and reset
module tb_debug_mem_arbiter;
    logic        cpu_clk = 1'b0, sys_rstn = 1'b0;
    logic        cpu_halt = 1'b0, cpu_ce = 1'b0, cpu_we = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ready;
    logic        dbg_ce = 1'b0, dbg_we = 1'b0;
    logic [63:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
    logic        dbg_rdata_ready;
    logic        mem_ce, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        dbg_overrun, timeout_err;

    debug_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .cpu_clk(cpu_clk), .sys_rstn(sys_rstn), .cpu_halt(cpu_halt),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_rdata_ready(dbg_rdata_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_overrun(dbg_overrun), .timeout_err(timeout_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0, n_fail = 0;
    int mem_lat = 3, lat = 0, cyc = 0, hi_cyc = 0, last_gap = 0;
    int n_cpu_rdy = 0, n_dbg_rdy = 0, n_ce_cyc = 0, n_unstable = 0;
    logic [63:0] rd_val = '0, last_cpu_rdata = '0;
    logic [63:0] cap_addr = '0, cap_wdata = '0, rise_addr = '0, rise_wdata = '0;
    logic        cap_we = 1'b0, rise_we = 1'b0, mce_q = 1'b0;
    logic [63:0] grants[$];

    // memory model answers after mem_lat cycles of mem_ce (0 = never); monitors count pulses
    always @(negedge cpu_clk) begin
        cyc++;
        if (mem_ready) mem_ready = 1'b0;
        else if (mem_ce) begin
            lat++;
            if (mem_lat != 0 && lat == mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = rd_val;
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                lat = 0;
            end
        end else lat = 0;
        if (cpu_ready) begin n_cpu_rdy++; last_cpu_rdata = cpu_rdata; end
        if (dbg_rdata_ready) n_dbg_rdy++;
        if (mem_ce && !mce_q) begin
            grants.push_back(mem_addr);
            last_gap = cyc - hi_cyc - 1;
            rise_we = mem_we; rise_addr = mem_addr; rise_wdata = mem_wdata;
        end
        if (mem_ce) begin
            hi_cyc = cyc;
            n_ce_cyc++;
            if (mem_we !== rise_we || mem_addr !== rise_addr || mem_wdata !== rise_wdata) n_unstable++;
        end
        mce_q = mem_ce;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge cpu_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (cpu_ready) cpu_ce = 1'b0;
        end
    endtask

    task automatic clear_stats();
        n_cpu_rdy = 0; n_dbg_rdy = 0; n_ce_cyc = 0;
        grants.delete();
    endtask

    task automatic dbg_pulse(input logic we, input logic [63:0] addr, input logic [63:0] wd);
        dbg_ce = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        tick();
        dbg_ce = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("rst_mem_ce", 64'(mem_ce), 0);
        check("rst_cpu_ready", 64'(cpu_ready), 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_flags", {62'd0, dbg_overrun, timeout_err}, 0);
        sys_rstn = 1'b1;
        tick();

        // debug read, 3-cycle memory
        clear_stats(); rd_val = 64'hCAFE;
        dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h100;
        tick();
        dbg_ce = 1'b0;
        check("t1_ce_after_e0", 64'(mem_ce), 0);
        tick();
        check("t1_ce_after_e1", 64'(mem_ce), 1);
        check("t1_addr", mem_addr, 64'h100);
        check("t1_we", 64'(mem_we), 0);
        run(10);
        check("t1_dbg_rdata", dbg_rdata, 64'hCAFE);
        check("t1_dbg_rdy_cnt", 64'(n_dbg_rdy), 1);
        check("t1_cpu_rdy_cnt", 64'(n_cpu_rdy), 0);

        // debug write
        clear_stats();
        dbg_pulse(1'b1, 64'h8, 64'h55);
        run(10);
        check("t2_we", 64'(cap_we), 1);
        check("t2_addr", cap_addr, 64'h8);
        check("t2_wdata", cap_wdata, 64'h55);
        check("t2_no_rdy", 64'(n_dbg_rdy), 0);
        check("t2_rdata_hold", dbg_rdata, 64'hCAFE);

        // same-cycle CPU and debug requests
        clear_stats(); rd_val = 64'h1234;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h200;
        dbg_pulse(1'b0, 64'h300, 64'h0);
        run(20);
        check("t3_grant_cnt", 64'(grants.size()), 2);
        check("t3_first_dbg", grants[0], 64'h300);
        check("t3_second_cpu", grants[1], 64'h200);
        check("t3_idle_gap", 64'(last_gap), 1);
        check("t3_cpu_rdy_cnt", 64'(n_cpu_rdy), 1);
        check("t3_cpu_rdata", last_cpu_rdata, 64'h1234);
        check("t3_dbg_rdy_cnt", 64'(n_dbg_rdy), 1);

        // halted CPU gets no grant, debug still served
        clear_stats(); rd_val = 64'h77;
        cpu_halt = 1'b1; cpu_ce = 1'b1; cpu_addr = 64'h400;
        run(20);
        check("t4_halt_no_ce", 64'(n_ce_cyc), 0);
        dbg_pulse(1'b0, 64'h500, 64'h0);
        run(10);
        check("t4_dbg_grant", grants[0], 64'h500);
        check("t4_dbg_rdata", dbg_rdata, 64'h77);
        rd_val = 64'h4444; cpu_halt = 1'b0;
        run(10);
        check("t4_cpu_grant", grants[1], 64'h400);
        check("t4_cpu_rdy_cnt", 64'(n_cpu_rdy), 1);
        check("t4_cpu_rdata", last_cpu_rdata, 64'h4444);

        // debug pulses during a long CPU write
        clear_stats(); mem_lat = 6; rd_val = 64'h99;
        check("t5_overrun_clear", 64'(dbg_overrun), 0);
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h600; cpu_wdata = 64'hAA;
        tick();
        dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h700;
        tick(); tick(); tick();
        dbg_ce = 1'b0;
        run(30);
        check("t5_overrun", 64'(dbg_overrun), 1);
        check("t5_grant_cnt", 64'(grants.size()), 2);
        check("t5_dbg_after_cpu", grants[1], 64'h700);
        check("t5_dbg_rdy_cnt", 64'(n_dbg_rdy), 1);
        check("t5_cpu_rdy_cnt", 64'(n_cpu_rdy), 1);
        check("t5_cpu_rdata_hold", cpu_rdata, 64'h4444);
        check("t5_dbg_rdata", dbg_rdata, 64'h99);
        check("xfer_stable", 64'(n_unstable), 0);

        // watchdog abort, then async reset mid-transfer
        clear_stats(); mem_lat = 0;
        check("t6_tout_clear", 64'(timeout_err), 0);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h800;
        run(20);
        check("t6_ce_cycles", 64'(n_ce_cyc), 8);
        check("t6_cpu_rdy_cnt", 64'(n_cpu_rdy), 1);
        check("t6_abort_data", last_cpu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_timeout_err", 64'(timeout_err), 1);
        dbg_pulse(1'b1, 64'h900, 64'h1);
        tick();
        check("t6_ce_before_rst", 64'(mem_ce), 1);
        sys_rstn = 1'b0;
        #1;
        check("t6_rst_mem_ce", 64'(mem_ce), 0);
        check("t6_rst_mem_bus", mem_addr | mem_wdata | 64'(mem_we), 0);
        check("t6_rst_rdata", cpu_rdata | dbg_rdata, 0);
        check("t6_rst_flags", {62'd0, dbg_overrun, timeout_err}, 0);
        run(2);
        sys_rstn = 1'b1;
        run(2);
        check("t6_idle_after_rst", 64'(mem_ce), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
